// File: rtl/sram_blk_alloc_if.sv
// Request / release / write-address / descriptor bundle for the SRAM block allocator.
// Latency: none (wires only).
// Backpressure: o_pkt_rdy gates packet admission; other channels are strobes.
// Signals: i_pkt_* (admission), i_free_* (block release), o_sram_* (write addresses),
//          o_desc_* (finished-packet descriptor), o_free_cnt / o_init_done / o_err (status).
interface sram_blk_alloc_if #(
    parameter int BLK_ADDR_WIDTH = 10,
    parameter int LEN_WIDTH      = 8
);
    logic                      i_pkt_vld;
    logic [LEN_WIDTH-1:0]      i_pkt_len;
    logic                      o_pkt_rdy;
    logic                      i_free_vld;
    logic [BLK_ADDR_WIDTH-1:0] i_free_addr;
    logic [BLK_ADDR_WIDTH-1:0] o_sram_addr;
    logic                      o_sram_addr_vld;
    logic                      o_desc_vld;
    logic [BLK_ADDR_WIDTH-1:0] o_desc_head;
    logic [LEN_WIDTH-1:0]      o_desc_len;
    logic [BLK_ADDR_WIDTH:0]   o_free_cnt;
    logic                      o_init_done;
    logic                      o_err;

    // Allocator side.
    modport slave (
        input  i_pkt_vld, i_pkt_len, i_free_vld, i_free_addr,
        output o_pkt_rdy, o_sram_addr, o_sram_addr_vld, o_desc_vld,
               o_desc_head, o_desc_len, o_free_cnt, o_init_done, o_err
    );

    // Requester / releaser side.
    modport master (
        output i_pkt_vld, i_pkt_len, i_free_vld, i_free_addr,
        input  o_pkt_rdy, o_sram_addr, o_sram_addr_vld, o_desc_vld,
               o_desc_head, o_desc_len, o_free_cnt, o_init_done, o_err
    );
endinterface

// File: rtl/sram_blk_alloc.sv
// Circular free-list block allocator issuing one SRAM block address per packet word.
// Latency: handshake in cycle T -> addresses in T+1..T+len, descriptor in T+len+1.
// Backpressure: o_pkt_rdy only in IDLE and only when the whole packet fits in free blocks.
// Ports: i_clk, i_rst (async active-high), bus (sram_blk_alloc_if.slave): packet request,
//        block release, write-address stream, descriptor pulse, free count, init/err status.
module sram_blk_alloc #(
    parameter int BLK_ADDR_WIDTH = 10,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    sram_blk_alloc_if.slave      bus
);
    localparam int NUM_BLK = 1 << BLK_ADDR_WIDTH;
    localparam int CNT_W   = BLK_ADDR_WIDTH + 1;
    localparam int CMP_W   = (LEN_WIDTH > CNT_W) ? LEN_WIDTH : CNT_W;

    localparam logic [CNT_W-1:0]          FULL_CNT  = {1'b1, {BLK_ADDR_WIDTH{1'b0}}};
    localparam logic [CNT_W-1:0]          LAST_INIT = {1'b0, {BLK_ADDR_WIDTH{1'b1}}};
    localparam logic [CNT_W-1:0]          CNT_ONE   = CNT_W'(1);
    localparam logic [BLK_ADDR_WIDTH-1:0] PTR_ONE   = BLK_ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]      LEN_ONE   = LEN_WIDTH'(1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ALLOC, ST_DESC} state_t;

    state_t                    state_q, state_d;
    logic [BLK_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [BLK_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [LEN_WIDTH-1:0]      remain_q, remain_d;
    logic [BLK_ADDR_WIDTH-1:0] head_q, head_d;
    logic [BLK_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic                      sram_vld_q, sram_vld_d;
    logic                      desc_vld_q, desc_vld_d;
    logic [BLK_ADDR_WIDTH-1:0] desc_head_q, desc_head_d;
    logic [LEN_WIDTH-1:0]      desc_len_q, desc_len_d;
    logic                      init_done_q, init_done_d;
    logic                      err_q, err_d;

    logic [BLK_ADDR_WIDTH-1:0] mem [NUM_BLK];
    logic [BLK_ADDR_WIDTH-1:0] mem_rd;
    logic                      mem_we;
    logic [BLK_ADDR_WIDTH-1:0] mem_waddr;
    logic [BLK_ADDR_WIDTH-1:0] mem_wdata;

    logic                      pkt_rdy;
    logic                      pop;
    logic                      push;
    logic [CMP_W-1:0]          len_ext;
    logic [CMP_W-1:0]          cnt_ext;

    assign mem_rd  = mem[rd_ptr_q];
    assign len_ext = CMP_W'(bus.i_pkt_len);
    assign cnt_ext = CMP_W'(cnt_q);

    // Free-list storage; contents are rebuilt by INIT so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        remain_d    = remain_q;
        head_d      = head_q;
        sram_addr_d = '0;
        sram_vld_d  = 1'b0;
        desc_vld_d  = 1'b0;
        desc_head_d = '0;
        desc_len_d  = '0;
        init_done_d = init_done_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;
        mem_wdata   = bus.i_free_addr;
        pkt_rdy     = 1'b0;
        pop         = 1'b0;
        push        = 1'b0;

        case (state_q)
            ST_INIT: begin
                // Seed the list with 0..NUM_BLK-1; releases are not accepted yet.
                mem_we    = 1'b1;
                mem_wdata = wr_ptr_q;
                wr_ptr_d  = wr_ptr_q + PTR_ONE;
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == LAST_INIT) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                // Whole packet must fit in the registered count (all-or-nothing).
                pkt_rdy = (len_ext <= cnt_ext);
                if (bus.i_pkt_vld && pkt_rdy && (bus.i_pkt_len != '0)) begin
                    // First pop happens on the handshake edge so the address is
                    // registered and visible in the cycle right after acceptance.
                    pop      = 1'b1;
                    head_d   = mem_rd;
                    len_d    = bus.i_pkt_len;
                    remain_d = bus.i_pkt_len - LEN_ONE;
                    state_d  = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                if (remain_q != '0) begin
                    pop      = 1'b1;
                    remain_d = remain_q - LEN_ONE;
                end else begin
                    state_d     = ST_DESC;
                    desc_vld_d  = 1'b1;
                    desc_head_d = head_q;
                    desc_len_d  = len_q;
                end
            end
            ST_DESC: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (pop) begin
            sram_addr_d = mem_rd;
            sram_vld_d  = 1'b1;
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
        end

        // Releases; a full list drops the block and flags the error.
        if ((state_q != ST_INIT) && bus.i_free_vld) begin
            if (cnt_q == FULL_CNT) begin
                err_d = 1'b1;
            end else begin
                push     = 1'b1;
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
        end

        if (state_q != ST_INIT) begin
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_INIT;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            remain_q    <= '0;
            head_q      <= '0;
            sram_addr_q <= '0;
            sram_vld_q  <= 1'b0;
            desc_vld_q  <= 1'b0;
            desc_head_q <= '0;
            desc_len_q  <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            remain_q    <= remain_d;
            head_q      <= head_d;
            sram_addr_q <= sram_addr_d;
            sram_vld_q  <= sram_vld_d;
            desc_vld_q  <= desc_vld_d;
            desc_head_q <= desc_head_d;
            desc_len_q  <= desc_len_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_pkt_rdy       = pkt_rdy;
    assign bus.o_sram_addr     = sram_addr_q;
    assign bus.o_sram_addr_vld = sram_vld_q;
    assign bus.o_desc_vld      = desc_vld_q;
    assign bus.o_desc_head     = desc_head_q;
    assign bus.o_desc_len      = desc_len_q;
    assign bus.o_free_cnt      = cnt_q;
    assign bus.o_init_done     = init_done_q;
    assign bus.o_err           = err_q;
endmodule

// File: doc/sram_blk_alloc.md
Name: sram_blk_alloc

Overview:
Free-block allocator and write-address sequencer that sits directly upstream of the SRAM write stage. It keeps a circular free list of SRAM block addresses. For each admitted packet it issues one block address per word on o_sram_addr/o_sram_addr_vld; the write stage pops the data FIFO on that valid. When a packet finishes it emits a descriptor (head block, length) to the queue manager. Blocks are returned through a release port.

Parameters:
BLK_ADDR_WIDTH, 10, SRAM block address width; NUM_BLK = 2**BLK_ADDR_WIDTH
LEN_WIDTH, 8, packet length field width, in words

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, asynchronous, active-high
i_pkt_vld  input  1  packet request; its words are already resident in the data FIFO
i_pkt_len  input  LEN_WIDTH  packet length in words (one block per word)
o_pkt_rdy  output  1  request accepted when i_pkt_vld & o_pkt_rdy
i_free_vld  input  1  block release strobe
i_free_addr  input  BLK_ADDR_WIDTH  released block address
o_sram_addr  output  BLK_ADDR_WIDTH  block address to the write stage
o_sram_addr_vld  output  1  address valid; one word per cycle
o_desc_vld  output  1  one-cycle descriptor pulse
o_desc_head  output  BLK_ADDR_WIDTH  first block of the packet
o_desc_len  output  LEN_WIDTH  packet length
o_free_cnt  output  BLK_ADDR_WIDTH+1  blocks currently free
o_init_done  output  1  free list initialised
o_err  output  1  sticky error flag: release on a full list

Behaviour:
- Reset (async, i_rst=1):
  - State goes to INIT; read/write pointers 0; count 0.
  - All outputs 0, including o_err.
- Free list: NUM_BLK-entry circular buffer with rd_ptr, wr_ptr and count. Pointers wrap from NUM_BLK-1 to 0.
- INIT:
  - Writes addresses 0..NUM_BLK-1 in order, one per cycle; count increments each cycle.
  - After NUM_BLK cycles: o_init_done=1, go to IDLE.
  - During INIT, o_pkt_rdy=0 and i_free_vld is ignored.
- IDLE:
  - o_pkt_rdy = 1 when i_pkt_len <= o_free_cnt; the count used is the current registered value, and a same-cycle release is not counted.
  - Admission is all-or-nothing; no partial allocation.
  - Accept with len=0: descriptor dropped, no output, stay in IDLE.
  - Accept with len>0: latch len, go to ALLOC.
- ALLOC:
  - Lasts exactly len cycles.
  - Each cycle pops the free-list head into registered o_sram_addr with o_sram_addr_vld=1.
  - The first popped address is latched as head.
  - If handshake is in cycle T, addresses are valid in cycles T+1..T+len, back-to-back with no gaps.
  - o_pkt_rdy=0. Then go to DESC.
- DESC:
  - One cycle: o_desc_vld=1 with o_desc_head and o_desc_len; o_sram_addr_vld=0; o_pkt_rdy=0.
  - Next state IDLE. The earliest next acceptance is in cycle T+len+2.
- Outside ALLOC: o_sram_addr=0 and o_sram_addr_vld=0. o_desc_* are 0 when o_desc_vld=0.
- Release:
  - In IDLE/ALLOC/DESC, i_free_vld pushes i_free_addr at wr_ptr.
  - Push and pop in the same cycle: both pointers advance and the count is unchanged.
  - Push with count==NUM_BLK: ignored; o_err set and held until reset.
- The allocator never pops with count==0; this is guaranteed by the admission check.
- No duplicate-release check.
- o_free_cnt is registered and reflects the count after the previous cycle's push/pop.
- Reset mid-ALLOC: immediate abort. Outputs clear asynchronously. The free list is rebuilt by INIT. The partially allocated packet is lost.

Test Plan:
- BLK_ADDR_WIDTH=4. Release reset, then count cycles → o_init_done rises after 16 cycles; o_free_cnt=16; o_pkt_rdy=0 throughout INIT.
- After init, request len=3 → addresses 0,1,2 on three consecutive valid cycles. Next cycle: desc head=0, len=3. o_free_cnt=13.
- Free 1,0 in that order; request len=14 → addresses 3..15 then 1 (pointer wraps); desc head=3, len=14.
- Free count=2; request len=5 → o_pkt_rdy=0, request held. Release 3 blocks → o_pkt_rdy rises the cycle after count reaches 5.
- During ALLOC of len=4, release block 7 concurrently → o_free_cnt decreases by 3, not 4; block 7 is later allocated in FIFO order. Release with count=16 → o_err=1 and stays 1.
- Assert i_rst in the 2nd ALLOC cycle → outputs 0 immediately. After release: INIT reruns and the first allocation after it is address 0.
